// File: rtl/v810_bus_hold.sv
`default_nettype none
// ============================================================================
// Module   : v810_bus_hold
// Brief    : HLDRQ/HLDAK bus-hold arbiter for the V810 external bus. Stalls
//            the CPU memory unit at a bus-cycle boundary, floats the CPU pins
//            once the bus is quiet, acknowledges the external master and
//            keeps the CPU on the bus for a minimum tenure between holds.
// Revision : 1.0 - initial release
// ============================================================================
module v810_bus_hold #(
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_CPU_CYCLES = 4,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             CE,
    input  logic             HLDRQn,
    output logic             HLDAKn,
    input  logic             BCYSTn,
    input  logic             DAn,
    input  logic             READYn,
    output logic             CPU_STALL,
    output logic             BUS_OE,
    output logic             HOLD_ACTIVE,
    output logic [CNT_W-1:0] HOLD_CYC
);

    localparam int TEN_W = (MIN_CPU_CYCLES > 0) ? $clog2(MIN_CPU_CYCLES + 1) : 1;
    localparam logic [TEN_W-1:0] c_TEN_LOAD = TEN_W'(MIN_CPU_CYCLES);

    localparam logic [2:0] c_ST_CPU    = 3'd0;
    localparam logic [2:0] c_ST_DRAIN  = 3'd1;
    localparam logic [2:0] c_ST_FLOAT  = 3'd2;
    localparam logic [2:0] c_ST_HOLD   = 3'd3;
    localparam logic [2:0] c_ST_RESUME = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic                   r_busy;
    logic [TEN_W-1:0]       r_tenure;
    logic [CNT_W-1:0]       r_hold_cyc;
    logic                   r_hldakn;
    logic                   r_stall;
    logic                   r_oe;
    logic                   r_hold;
    logic                   w_hreq;
    logic                   w_quiet;
    logic                   w_eligible;
    logic                   w_cpu_owns;

    assign w_hreq     = ~r_sync[SYNC_STAGES-1];
    assign w_quiet    = ~r_busy & BCYSTn & DAn;
    assign w_eligible = w_hreq & (r_tenure == '0);
    // Bus-cycle tracking only matters while the CPU may be running cycles;
    // READYn belongs to the external master once the pins are floated.
    assign w_cpu_owns = (r_state == c_ST_CPU) || (r_state == c_ST_DRAIN);

    // Synchronize the asynchronous hold request; idles high (no request).
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) r_sync <= '1;
            else     r_sync <= SYNC_STAGES'({r_sync, HLDRQn});
        end
    end

    // Track an outstanding CPU bus cycle from its start strobe to its ready.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                r_busy <= 1'b0;
            end else if (w_cpu_owns) begin
                if (!BCYSTn)              r_busy <= 1'b1;
                else if (!DAn && !READYn) r_busy <= 1'b0;
            end
        end
    end

    // Next-state selection for the hold handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_CPU: begin
                if (w_eligible) w_state_nxt = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (!w_hreq)      w_state_nxt = c_ST_CPU;
                else if (w_quiet) w_state_nxt = c_ST_FLOAT;
            end
            c_ST_FLOAT:  w_state_nxt = w_hreq ? c_ST_HOLD : c_ST_RESUME;
            c_ST_HOLD: begin
                if (!w_hreq) w_state_nxt = c_ST_RESUME;
            end
            c_ST_RESUME: w_state_nxt = c_ST_CPU;
            default:     w_state_nxt = c_ST_CPU;
        endcase
    end

    // State register with outputs registered from the state being entered.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                r_state  <= c_ST_CPU;
                r_hldakn <= 1'b1;
                r_stall  <= 1'b0;
                r_oe     <= 1'b1;
                r_hold   <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_hldakn <= (w_state_nxt != c_ST_HOLD);
                r_stall  <= (w_state_nxt != c_ST_CPU);
                r_oe     <= (w_state_nxt == c_ST_CPU) || (w_state_nxt == c_ST_DRAIN);
                r_hold   <= (w_state_nxt == c_ST_HOLD);
            end
        end
    end

    // Minimum CPU tenure: reload when the bus comes back, count down in CPU.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES)
                r_tenure <= '0;
            else if (r_state == c_ST_RESUME)
                r_tenure <= c_TEN_LOAD;
            else if ((r_state == c_ST_CPU) && (r_tenure != '0))
                r_tenure <= r_tenure - TEN_W'(1);
        end
    end

    // Saturating count of cycles spent in the current/last hold tenure.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES)
                r_hold_cyc <= '0;
            else if ((r_state == c_ST_FLOAT) && (w_state_nxt == c_ST_HOLD))
                r_hold_cyc <= '0;
            else if ((r_state == c_ST_HOLD) && (r_hold_cyc != '1))
                r_hold_cyc <= r_hold_cyc + CNT_W'(1);
        end
    end

    assign HLDAKn      = r_hldakn;
    assign CPU_STALL   = r_stall;
    assign BUS_OE      = r_oe;
    assign HOLD_ACTIVE = r_hold;
    assign HOLD_CYC    = r_hold_cyc;

    // The CPU is stalled with its pins floated; a new bus cycle here would
    // collide with the external master.
    a_no_bcyst_while_held: assert property (
        @(posedge CLK) disable iff (RES)
        (CE && ((r_state == c_ST_FLOAT) || (r_state == c_ST_HOLD) || (r_state == c_ST_RESUME)))
        |-> BCYSTn
    ) else $fatal(1, "v810_bus_hold: bus cycle started while the bus is held");

endmodule
`default_nettype wire

// File: tb/tb_v810_bus_hold.sv
`default_nettype none
// ============================================================================
// Module   : tb_v810_bus_hold
// Brief    : Self-checking bench for v810_bus_hold: directed hold scenarios
//            with hand-computed cycle expectations, then randomized hold
//            requests, CPU bus cycles, clock enables and resets checked every
//            cycle against a behavioural model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_v810_bus_hold;

    localparam int SYNC_STAGES = 2;
    localparam int MIN_CPU     = 4;
    localparam int CNT_W       = 4;
    localparam int HC_MAX      = (1 << CNT_W) - 1;

    // Phases of bus ownership as seen from outside the arbiter.
    localparam int P_CPU    = 0;
    localparam int P_DRAIN  = 1;
    localparam int P_FLOAT  = 2;
    localparam int P_HOLD   = 3;
    localparam int P_RESUME = 4;

    logic             CLK    = 1'b0;
    logic             RES    = 1'b1;
    logic             CE     = 1'b1;
    logic             HLDRQn = 1'b1;
    logic             BCYSTn = 1'b1;
    logic             DAn    = 1'b1;
    logic             READYn = 1'b1;
    logic             HLDAKn;
    logic             CPU_STALL;
    logic             BUS_OE;
    logic             HOLD_ACTIVE;
    logic [CNT_W-1:0] HOLD_CYC;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Behavioural model state.
    bit rq_line[$];
    int phase    = P_CPU;
    bit m_busy   = 1'b0;
    int m_tenure = 0;
    int m_hcyc   = 0;
    bit e_hldakn = 1'b1;
    bit e_stall  = 1'b0;
    bit e_oe     = 1'b1;
    bit e_hold   = 1'b0;

    v810_bus_hold #(
        .SYNC_STAGES   (SYNC_STAGES),
        .MIN_CPU_CYCLES(MIN_CPU),
        .CNT_W         (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RES        (RES),
        .CE         (CE),
        .HLDRQn     (HLDRQn),
        .HLDAKn     (HLDAKn),
        .BCYSTn     (BCYSTn),
        .DAn        (DAn),
        .READYn     (READYn),
        .CPU_STALL  (CPU_STALL),
        .BUS_OE     (BUS_OE),
        .HOLD_ACTIVE(HOLD_ACTIVE),
        .HOLD_CYC   (HOLD_CYC)
    );

    initial forever #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    function automatic void set_expect();
        e_stall  = (phase != P_CPU);
        e_oe     = (phase == P_CPU) || (phase == P_DRAIN);
        e_hldakn = (phase != P_HOLD);
        e_hold   = (phase == P_HOLD);
    endfunction

    // One CE edge of the arbiter's rules, using the inputs present at the edge.
    task automatic model_step();
        int  nxt;
        bit  hreq;
        bit  quiet;
        if (!CE) return;
        if (RES) begin
            phase    = P_CPU;
            m_busy   = 1'b0;
            m_tenure = 0;
            m_hcyc   = 0;
            rq_line.delete();
            repeat (SYNC_STAGES) rq_line.push_back(1'b1);
            set_expect();
            return;
        end
        hreq  = !rq_line[SYNC_STAGES-1];
        quiet = !m_busy && BCYSTn && DAn;
        nxt   = phase;
        case (phase)
            P_CPU:    if (hreq && m_tenure == 0) nxt = P_DRAIN;
            P_DRAIN:  nxt = !hreq ? P_CPU : (quiet ? P_FLOAT : P_DRAIN);
            P_FLOAT:  nxt = hreq ? P_HOLD : P_RESUME;
            P_HOLD:   nxt = hreq ? P_HOLD : P_RESUME;
            default:  nxt = P_CPU;
        endcase
        if (phase == P_FLOAT && nxt == P_HOLD)     m_hcyc = 0;
        else if (phase == P_HOLD && m_hcyc < HC_MAX) m_hcyc++;
        if (phase == P_RESUME)                     m_tenure = MIN_CPU;
        else if (phase == P_CPU && m_tenure > 0)   m_tenure--;
        if (phase == P_CPU || phase == P_DRAIN) begin
            if (!BCYSTn)              m_busy = 1'b1;
            else if (!DAn && !READYn) m_busy = 1'b0;
        end
        rq_line.push_front(HLDRQn);
        void'(rq_line.pop_back());
        phase = nxt;
        set_expect();
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // Every-cycle comparison against the model, mid-period.
    initial forever begin
        @(negedge CLK);
        if (chk_on) begin
            check("HLDAKn",      HLDAKn,      e_hldakn);
            check("CPU_STALL",   CPU_STALL,   e_stall);
            check("BUS_OE",      BUS_OE,      e_oe);
            check("HOLD_ACTIVE", HOLD_ACTIVE, e_hold);
            check("HOLD_CYC",    HOLD_CYC,    m_hcyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_stall[5];
        int exp_oe[5];
        int exp_hak[5];
        int n0;
        int first_float;
        bit hak_early;
        int rq_left;
        int drv;
        bit second;
        bit prev_stall;
        bit ce_was;
        bit res_was;

        exp_stall = '{0, 0, 1, 1, 1};
        exp_oe    = '{1, 1, 1, 0, 0};
        exp_hak   = '{1, 1, 1, 1, 0};

        tick();
        tick();
        check("rst_HLDAKn",      HLDAKn,      1);
        check("rst_CPU_STALL",   CPU_STALL,   0);
        check("rst_BUS_OE",      BUS_OE,      1);
        check("rst_HOLD_ACTIVE", HOLD_ACTIVE, 0);
        check("rst_HOLD_CYC",    HOLD_CYC,    0);
        RES    = 1'b0;
        chk_on = 1'b1;

        // Idle bus: request at cycle 0 -> stall at 3, float at 4, ack at 5.
        HLDRQn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("grant_CPU_STALL", CPU_STALL, exp_stall[k]);
            check("grant_BUS_OE",    BUS_OE,    exp_oe[k]);
            check("grant_HLDAKn",    HLDAKn,    exp_hak[k]);
        end
        repeat (10) tick();
        check("hold10_HOLD_CYC", HOLD_CYC, 10);
        HLDRQn = 1'b1;
        tick();
        tick();
        check("release_sync_HLDAKn", HLDAKn, 0);
        tick();
        check("release_HLDAKn",    HLDAKn,    1);
        check("release_BUS_OE",    BUS_OE,    0);
        check("release_CPU_STALL", CPU_STALL, 1);
        HLDRQn = 1'b0;
        tick();
        check("resume_BUS_OE",    BUS_OE,    1);
        check("resume_CPU_STALL", CPU_STALL, 0);
        check("resume_HOLD_CYC",  HOLD_CYC,  13);

        // Back-to-back request: the CPU keeps the bus for the four tenure
        // cycles plus the cycle in which the request becomes eligible, and
        // completes one zero-wait access inside that window.
        n0 = 0;
        for (int i = 0; i < 20 && CPU_STALL == 1'b0; i++) begin
            n0++;
            BCYSTn = (i != 0);
            DAn    = (i != 1);
            READYn = (i != 1);
            tick();
        end
        check("b2b_stall_low_cycles", n0, MIN_CPU + 1);
        tick();
        check("b2b_BUS_OE", BUS_OE, 0);
        tick();
        check("b2b_HLDAKn", HLDAKn, 0);
        repeat (7) tick();
        check("hold7_HOLD_CYC", HOLD_CYC, 7);

        // Clock enable low freezes everything.
        CE = 1'b0;
        repeat (5) tick();
        check("ce_freeze_HOLD_CYC", HOLD_CYC, 7);
        check("ce_freeze_HLDAKn",   HLDAKn,   0);

        // Reset in the middle of a hold.
        CE  = 1'b1;
        RES = 1'b1;
        tick();
        check("rst_hold_HLDAKn",    HLDAKn,    1);
        check("rst_hold_BUS_OE",    BUS_OE,    1);
        check("rst_hold_CPU_STALL", CPU_STALL, 0);
        check("rst_hold_HOLD_CYC",  HOLD_CYC,  0);
        RES = 1'b0;

        // Request arrives during a read with three wait cycles: float only
        // after the access completes and the bus has gone quiet.
        first_float = -1;
        hak_early   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            BCYSTn = (i != 0);
            DAn    = !(i >= 1 && i <= 4);
            READYn = (i != 4);
            tick();
            if (first_float < 0 && HLDAKn == 1'b0) hak_early = 1'b1;
            if (first_float < 0 && BUS_OE == 1'b0) first_float = i + 1;
        end
        check("wait_read_float_edge",   first_float, 6);
        check("wait_read_no_early_ack", hak_early,   0);
        HLDRQn = 1'b1;
        BCYSTn = 1'b1;
        DAn    = 1'b1;
        READYn = 1'b1;

        // Randomized traffic: drv 0 idle, 1 T1/T1S, 2 T2/T2S.
        rq_left    = $urandom_range(1, 25);
        drv        = 0;
        second     = 1'b0;
        prev_stall = e_stall;
        for (int c = 0; c < 3000; c++) begin
            tick();
            ce_was  = CE;
            res_was = RES;
            if (ce_was) begin
                if (res_was) begin
                    drv    = 0;
                    second = 1'b0;
                end else if (drv == 1) begin
                    drv = 2;
                end else if (drv == 2) begin
                    if (!READYn) begin
                        if (second) begin
                            drv    = 1;
                            second = 1'b0;
                        end else begin
                            drv = 0;
                        end
                    end
                end else if ((!e_stall || !prev_stall) && ($urandom % 3 == 0)) begin
                    drv    = 1;
                    second = ($urandom % 2 == 0);
                end
                prev_stall = e_stall;
            end
            BCYSTn = (drv != 1);
            DAn    = (drv != 2);
            READYn = ($urandom % 3 != 0);
            rq_left--;
            if (rq_left <= 0) begin
                HLDRQn  = ~HLDRQn;
                rq_left = $urandom_range(1, 25);
            end
            CE  = ($urandom % 8 != 0);
            RES = ($urandom % 400 == 0);
        end
        RES = 1'b0;
        CE  = 1'b1;
        tick();
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
